// File: rtl/puf_pkg.sv
// Shared definitions for the PUF batch evaluation sequencer: state encoding,
// output byte layout and the datapath widths shared with testPUF.
package puf_pkg;

  localparam int PDL_CONFIG_WIDTH = 128;
  localparam int CHALLENGE_WIDTH  = 64;
  localparam int RESPONSE_WIDTH   = 6;

  // Field positions inside the byte written per challenge.
  localparam int TIMEOUT_BIT = 7;
  localparam int RESP_LSB    = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_TRIG  = 3'd2,
    S_WAIT  = 3'd3,
    S_VOTE  = 3'd4,
    S_WRITE = 3'd5,
    S_NEXT  = 3'd6,
    S_FIN   = 3'd7
  } state_e;

endpackage

// File: rtl/puf_majority_vote.sv
// Per-bit vote counters for repeated PUF evaluations; a bit wins only with a
// strict majority of all repeats, so ties and timed-out repeats count as 0.
module puf_majority_vote #(
  parameter int RESPONSE_WIDTH = 6,
  parameter int REPEAT_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      reset_ni,
  input  logic                      clr_i,
  input  logic                      acc_en_i,
  input  logic [RESPONSE_WIDTH-1:0] resp_i,
  input  logic [REPEAT_WIDTH:0]     repeats_eff_i,
  output logic [RESPONSE_WIDTH-1:0] majority_o
);

  genvar gi;
  generate
    for (gi = 0; gi < RESPONSE_WIDTH; gi++) begin : g_bit
      logic [REPEAT_WIDTH:0] cnt_q;

      always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
          cnt_q <= '0;
        end else if (clr_i) begin
          cnt_q <= '0;
        end else if (acc_en_i && resp_i[gi]) begin
          cnt_q <= cnt_q + (REPEAT_WIDTH+1)'(1);
        end
      end

      // 2*count > R' evaluated one bit wider so neither side can overflow.
      assign majority_o[gi] = ({cnt_q, 1'b0} > {1'b0, repeats_eff_i});
    end
  endgenerate

endmodule

// File: rtl/puf_eval_sequencer.sv
// Batch controller: runs N consecutive challenges, each evaluated R times,
// majority-votes the raw responses and writes one byte per challenge.
module puf_eval_sequencer #(
  parameter int PDL_CONFIG_WIDTH     = puf_pkg::PDL_CONFIG_WIDTH,
  parameter int CHALLENGE_WIDTH      = puf_pkg::CHALLENGE_WIDTH,
  parameter int RESPONSE_WIDTH       = puf_pkg::RESPONSE_WIDTH,
  parameter int OUTMEM_ADDRESS_WIDTH = 13,
  parameter int REPEAT_WIDTH         = 4,
  parameter int TIMEOUT_CYCLES       = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            abort,
  input  logic [PDL_CONFIG_WIDTH-1:0]     cfg_pdl_config,
  input  logic [CHALLENGE_WIDTH-1:0]      cfg_challenge_base,
  input  logic [OUTMEM_ADDRESS_WIDTH-1:0] cfg_num_evals,
  input  logic [REPEAT_WIDTH-1:0]         cfg_num_repeats,
  output logic                            busy,
  output logic                            done,
  output logic                            timeout_seen,
  output logic                            puf_trigger,
  output logic [PDL_CONFIG_WIDTH-1:0]     puf_pdl_config,
  output logic [CHALLENGE_WIDTH-1:0]      puf_challenge,
  input  logic                            puf_done,
  input  logic [RESPONSE_WIDTH-1:0]       puf_raw_response,
  output logic                            wr_req,
  input  logic                            wr_ack,
  output logic [OUTMEM_ADDRESS_WIDTH-1:0] wr_addr,
  output logic [7:0]                      wr_data
);

  import puf_pkg::*;

  localparam int WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_e                          state_q;
  logic                            busy_q, done_q, timeout_seen_q, trigger_q;
  logic                            tflag_q, wr_req_q;
  logic [PDL_CONFIG_WIDTH-1:0]     pdl_q;
  logic [CHALLENGE_WIDTH-1:0]      chal_q;
  logic [OUTMEM_ADDRESS_WIDTH-1:0] num_evals_q, eval_idx_q, wr_addr_q;
  logic [REPEAT_WIDTH-1:0]         repeats_q, rep_idx_q;
  logic [WAIT_W-1:0]               wait_cnt_q;
  logic [7:0]                      wr_data_q, wr_data_d;
  logic [REPEAT_WIDTH:0]           rep_cnt_d;
  logic [RESPONSE_WIDTH-1:0]       majority;
  logic                            vote_clr, vote_acc;

  assign vote_clr  = ((state_q == S_IDLE) && start) || (state_q == S_NEXT);
  assign vote_acc  = (state_q == S_WAIT) && puf_done && !abort;
  assign rep_cnt_d = {1'b0, rep_idx_q} + (REPEAT_WIDTH+1)'(1);

  puf_majority_vote #(
    .RESPONSE_WIDTH(RESPONSE_WIDTH),
    .REPEAT_WIDTH  (REPEAT_WIDTH)
  ) u_vote (
    .clk          (clk),
    .reset_ni     (reset),
    .clr_i        (vote_clr),
    .acc_en_i     (vote_acc),
    .resp_i       (puf_raw_response),
    .repeats_eff_i({1'b0, repeats_q}),
    .majority_o   (majority)
  );

  always_comb begin
    wr_data_d = '0;
    wr_data_d[TIMEOUT_BIT] = tflag_q;
    wr_data_d[RESP_LSB +: RESPONSE_WIDTH] = majority;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      timeout_seen_q <= 1'b0;
      trigger_q      <= 1'b0;
      tflag_q        <= 1'b0;
      wr_req_q       <= 1'b0;
      pdl_q          <= '0;
      chal_q         <= '0;
      num_evals_q    <= '0;
      eval_idx_q     <= '0;
      wr_addr_q      <= '0;
      repeats_q      <= '0;
      rep_idx_q      <= '0;
      wait_cnt_q     <= '0;
      wr_data_q      <= '0;
    end else begin
      done_q    <= 1'b0;
      trigger_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pdl_q          <= cfg_pdl_config;
            chal_q         <= cfg_challenge_base;
            num_evals_q    <= cfg_num_evals;
            repeats_q      <= (cfg_num_repeats == '0) ? REPEAT_WIDTH'(1) : cfg_num_repeats;
            timeout_seen_q <= 1'b0;
            tflag_q        <= 1'b0;
            eval_idx_q     <= '0;
            rep_idx_q      <= '0;
            busy_q         <= 1'b1;
            state_q        <= (cfg_num_evals == '0) ? S_FIN : S_ARM;
          end
        end
        S_ARM: begin
          if (abort) begin
            state_q <= S_FIN;
          end else begin
            trigger_q <= 1'b1;
            state_q   <= S_TRIG;
          end
        end
        S_TRIG: begin
          if (abort) begin
            state_q <= S_FIN;
          end else begin
            wait_cnt_q <= '0;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            state_q <= S_FIN;
          end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
            // A response arriving on the last wait cycle still counts.
            if (puf_done) begin
              state_q <= S_VOTE;
            end else if (wait_cnt_q == TMO_LAST) begin
              tflag_q        <= 1'b1;
              timeout_seen_q <= 1'b1;
              state_q        <= S_VOTE;
            end
          end
        end
        S_VOTE: begin
          rep_idx_q <= rep_cnt_d[REPEAT_WIDTH-1:0];
          if (rep_cnt_d < {1'b0, repeats_q}) begin
            state_q <= S_ARM;
          end else begin
            wr_addr_q <= eval_idx_q;
            wr_data_q <= wr_data_d;
            wr_req_q  <= 1'b1;
            state_q   <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (wr_ack) begin
            wr_req_q <= 1'b0;
            state_q  <= abort ? S_FIN : S_NEXT;
          end
        end
        S_NEXT: begin
          eval_idx_q <= eval_idx_q + OUTMEM_ADDRESS_WIDTH'(1);
          chal_q     <= chal_q + CHALLENGE_WIDTH'(1);
          rep_idx_q  <= '0;
          tflag_q    <= 1'b0;
          state_q    <= (eval_idx_q == num_evals_q - OUTMEM_ADDRESS_WIDTH'(1)) ? S_FIN : S_ARM;
        end
        S_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign timeout_seen   = timeout_seen_q;
  assign puf_trigger    = trigger_q;
  assign puf_pdl_config = pdl_q;
  assign puf_challenge  = chal_q;
  assign wr_req         = wr_req_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;

endmodule
